pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, PC and target width in bits.
REQ-002 Parameter RESET_VECTOR, default 32'h00000000, PC value after reset.
REQ-003 Parameter EXC_VECTOR, default 32'h80000180, exception entry PC.
REQ-004 Parameter STEP, default 4, sequential increment.
REQ-005 Parameter RAS_DEPTH, default 4, return-address-stack entries; power of two, >=2.
REQ-006 Clk  in  1  clock; all state updates on rising edge.
REQ-007 Reset  in  1  synchronous, active-high reset, sampled on rising Clk.
REQ-008 Stall  in  1  hold PC and stack state this cycle.
REQ-009 ExcValid  in  1  exception redirect request.
REQ-010 BrTaken  in  1  conditional branch taken.
REQ-011 BrTarget  in  WIDTH  branch target.
REQ-012 JmpValid  in  1  unconditional jump.
REQ-013 JmpTarget  in  WIDTH  jump target.
REQ-014 Call  in  1  jump is a call; qualified by JmpValid.
REQ-015 Ret  in  1  return; redirect to stack top.
REQ-016 PCResult  out  WIDTH  registered current PC.
REQ-017 PCPlus  out  WIDTH  combinational PCResult+STEP.
REQ-018 RasCount  out  clog2(RAS_DEPTH)+1  registered number of valid stack entries.
REQ-019 RasUnderflow  out  1  registered one-cycle pulse: Ret accepted with empty stack.

Function
REQ-020 PCPlus SHALL equal (PCResult+STEP) mod 2^WIDTH; 32'hFFFFFFFC+4 wraps to 0.
REQ-021 Next-PC priority SHALL be: ExcValid > Ret > BrTaken > JmpValid > sequential (PCPlus).
REQ-022 ExcValid SHALL load EXC_VECTOR and clear RasCount to 0 regardless of Stall.
REQ-023 With Stall=1 and ExcValid=0, PCResult, stack contents, RasCount SHALL hold; RasUnderflow SHALL be 0 next cycle.
REQ-024 Ret with RasCount>0 SHALL load the top entry into PCResult and decrement RasCount.
REQ-025 Ret with RasCount=0 SHALL take the next-lower-priority source (branch, jump or sequential) and pulse RasUnderflow for exactly one cycle.
REQ-026 JmpValid&Call, when jump wins, SHALL load JmpTarget and push PCPlus.
REQ-027 Push with RasCount=RAS_DEPTH SHALL overwrite the oldest entry (circular pointer wrap); RasCount stays RAS_DEPTH.
REQ-028 Ret and JmpValid&Call in the same cycle with RasCount>0 SHALL load the popped value and replace the top entry with PCPlus; RasCount unchanged.
REQ-029 Call without JmpValid, or JmpValid&Call losing to BrTaken, SHALL NOT push.
REQ-030 Latency: every redirect SHALL appear on PCResult on the first rising edge after the request; no bubbles.

Reset
REQ-031 Reset=1 SHALL set PCResult=RESET_VECTOR, RasCount=0, RasUnderflow=0, stack pointer=0, overriding all inputs including ExcValid.
REQ-032 Stack entry contents after reset are don't-care; no entry is readable until pushed.
REQ-033 Before the first edge, PCResult SHALL power up as RESET_VECTOR in simulation.

Verification
REQ-034 Reset, then 3 idle cycles -> PCResult 0, 4, 8, 12; RasCount 0.
REQ-035 At PC=0x10, JmpValid&Call, JmpTarget=0x100; then Ret at 0x104 -> PC 0x100, 0x104, 0x14; RasCount 1 then 0.
REQ-036 Five calls with RAS_DEPTH=4 from PCs 0x0,0x100,0x200,0x300,0x400 -> RasCount saturates at 4; four Rets return 0x404,0x304,0x204,0x104; fifth Ret pulses RasUnderflow, PC goes sequential.
REQ-037 Stall=1 with BrTaken=1, BrTarget=0x40 for 2 cycles -> PCResult holds; ExcValid in stall -> PC=0x80000180, RasCount 0.
REQ-038 ExcValid, Ret, BrTaken, JmpValid asserted together with RasCount 2 -> PC=EXC_VECTOR, RasCount 0, no underflow pulse.
REQ-039 PC=0xFFFFFFFC idle -> PC 0x00000000; Reset asserted mid call sequence -> PC=0, RasCount=0 next edge.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: picks the next fetch PC from exception, return,
// branch, jump or sequential sources, and keeps a small circular return-address stack.
module pc_sequencer #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h00000000,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h80000180,
  parameter int               STEP         = 4,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Stall,
  input  logic                         ExcValid,
  input  logic                         BrTaken,
  input  logic [WIDTH-1:0]             BrTarget,
  input  logic                         JmpValid,
  input  logic [WIDTH-1:0]             JmpTarget,
  input  logic                         Call,
  input  logic                         Ret,
  output logic [WIDTH-1:0]             PCResult,
  output logic [WIDTH-1:0]             PCPlus,
  output logic [$clog2(RAS_DEPTH):0]   RasCount,
  output logic                         RasUnderflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  // Registered sequencer state; the PC carries a power-up value so that
  // simulation shows RESET_VECTOR before the first clock edge.
  logic [WIDTH-1:0] pc_p0 = RESET_VECTOR;
  logic [CNT_W-1:0] cnt_p0;
  logic [PTR_W-1:0] sp_p0;
  logic             uf_p0;
  logic [WIDTH-1:0] ras [RAS_DEPTH];

  logic [WIDTH-1:0] pc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [PTR_W-1:0] sp_nxt;
  logic             uf_nxt;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] top_idx;
  logic [WIDTH-1:0] pc_plus;

  assign pc_plus = pc_p0 + WIDTH'(STEP);
  // sp points at the next free slot, so the top entry sits one below it.
  assign top_idx = sp_p0 - PTR_W'(1);

  always_comb begin
    pc_nxt  = pc_p0;
    cnt_nxt = cnt_p0;
    sp_nxt  = sp_p0;
    uf_nxt  = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = sp_p0;
    if (ExcValid) begin
      pc_nxt  = EXC_VECTOR;
      cnt_nxt = '0;
      sp_nxt  = '0;
    end else if (!Stall) begin
      if (Ret && (cnt_p0 != '0)) begin
        pc_nxt = ras[top_idx];
        if (JmpValid && Call) begin
          // Pop and push together: the top slot is simply rewritten.
          wr_en  = 1'b1;
          wr_idx = top_idx;
        end else begin
          sp_nxt  = top_idx;
          cnt_nxt = cnt_p0 - CNT_W'(1);
        end
      end else begin
        uf_nxt = Ret;
        if (BrTaken) begin
          pc_nxt = BrTarget;
        end else if (JmpValid) begin
          pc_nxt = JmpTarget;
          if (Call) begin
            // A full stack keeps wrapping, silently dropping the oldest return.
            wr_en  = 1'b1;
            wr_idx = sp_p0;
            sp_nxt = sp_p0 + PTR_W'(1);
            if (cnt_p0 != CNT_FULL) begin
              cnt_nxt = cnt_p0 + CNT_W'(1);
            end
          end
        end else begin
          pc_nxt = pc_plus;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_p0  <= RESET_VECTOR;
      cnt_p0 <= '0;
      sp_p0  <= '0;
      uf_p0  <= 1'b0;
    end else begin
      pc_p0  <= pc_nxt;
      cnt_p0 <= cnt_nxt;
      sp_p0  <= sp_nxt;
      uf_p0  <= uf_nxt;
    end
  end

  // Stack storage has no reset; an entry is only read after it was pushed.
  always_ff @(posedge Clk) begin
    if (wr_en && !Reset) begin
      ras[wr_idx] <= pc_plus;
    end
  end

  assign PCResult     = pc_p0;
  assign PCPlus       = pc_plus;
  assign RasCount     = cnt_p0;
  assign RasUnderflow = uf_p0;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expected PC/stack state is queued when a
// step is driven and checked one edge later.
module tb_pc_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1, Stall = 1'b0, ExcValid = 1'b0, BrTaken = 1'b0;
  logic        JmpValid = 1'b0, Call = 1'b0, Ret = 1'b0;
  logic [31:0] BrTarget = '0, JmpTarget = '0;
  logic [31:0] PCResult, PCPlus;
  logic [2:0]  RasCount;
  logic        RasUnderflow;

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  cnt;
    logic        uf;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  pc_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .ExcValid(ExcValid),
    .BrTaken(BrTaken), .BrTarget(BrTarget), .JmpValid(JmpValid),
    .JmpTarget(JmpTarget), .Call(Call), .Ret(Ret), .PCResult(PCResult),
    .PCPlus(PCPlus), .RasCount(RasCount), .RasUnderflow(RasUnderflow)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drv(input logic rst, input logic stl, input logic exc, input logic rt,
                     input logic br, input logic [31:0] brt,
                     input logic jmp, input logic [31:0] jt, input logic cl);
    Reset = rst; Stall = stl; ExcValid = exc; Ret = rt;
    BrTaken = br; BrTarget = brt; JmpValid = jmp; JmpTarget = jt; Call = cl;
  endtask

  task automatic step(input logic [31:0] epc, input logic [2:0] ecnt, input logic euf,
                      input string tag);
    exp_t e;
    sb.push_back('{epc, ecnt, euf, tag});
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".pc"}, PCResult, e.pc);
    chk({e.tag, ".cnt"}, {29'd0, RasCount}, {29'd0, e.cnt});
    chk({e.tag, ".uf"}, {31'd0, RasUnderflow}, {31'd0, e.uf});
    chk({e.tag, ".plus"}, PCPlus, e.pc + 32'd4);
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0);
  endtask

  task automatic call_to(input logic [31:0] t);
    drv(0, 0, 0, 0, 0, 32'h0, 1, t, 1);
  endtask

  task automatic ret_only();
    drv(0, 0, 0, 1, 0, 32'h0, 0, 32'h0, 0);
  endtask

  initial begin
    #1;
    chk("powerup.pc", PCResult, 32'h0);

    // Reset and sequential fetch
    drv(1, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0); step(32'h0, 0, 0, "reset");
    idle(); step(32'h4, 0, 0, "seq1");
    step(32'h8, 0, 0, "seq2");
    step(32'hC, 0, 0, "seq3");
    step(32'h10, 0, 0, "seq4");

    // Call then return
    call_to(32'h100); step(32'h100, 1, 0, "call1");
    idle();           step(32'h104, 1, 0, "call1.seq");
    ret_only();       step(32'h14, 0, 0, "ret1");

    // Stack overflow wrap and underflow
    drv(1, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0); step(32'h0, 0, 0, "reset2");
    call_to(32'h100); step(32'h100, 1, 0, "ovf.c1");
    call_to(32'h200); step(32'h200, 2, 0, "ovf.c2");
    call_to(32'h300); step(32'h300, 3, 0, "ovf.c3");
    call_to(32'h400); step(32'h400, 4, 0, "ovf.c4");
    call_to(32'h500); step(32'h500, 4, 0, "ovf.c5");
    ret_only();       step(32'h404, 3, 0, "ovf.r1");
    step(32'h304, 2, 0, "ovf.r2");
    step(32'h204, 1, 0, "ovf.r3");
    step(32'h104, 0, 0, "ovf.r4");
    step(32'h108, 0, 1, "ovf.r5_underflow");
    idle();           step(32'h10C, 0, 0, "ovf.uf_clear");

    // Stall holds state; exception overrides stall
    call_to(32'h200); step(32'h200, 1, 0, "stall.setup");
    drv(0, 1, 0, 0, 1, 32'h40, 0, 32'h0, 0); step(32'h200, 1, 0, "stall.br1");
    drv(0, 1, 0, 1, 1, 32'h40, 0, 32'h0, 0); step(32'h200, 1, 0, "stall.br_ret");
    drv(0, 1, 1, 0, 0, 32'h0, 0, 32'h0, 0);  step(32'h80000180, 0, 0, "stall.exc");
    drv(0, 1, 0, 1, 0, 32'h0, 0, 32'h0, 0);  step(32'h80000180, 0, 0, "stall.ret_empty");

    // Simultaneous return and call replace the top entry
    call_to(32'h3000); step(32'h3000, 1, 0, "rc.setup");
    drv(0, 0, 0, 1, 0, 32'h0, 1, 32'h5000, 1); step(32'h80000184, 1, 0, "rc.both");
    ret_only();        step(32'h3004, 0, 0, "rc.ret");

    // Calls that must not push; underflow with branch fallback
    drv(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 1);    step(32'h3008, 0, 0, "nopush.call_only");
    drv(0, 0, 0, 0, 1, 32'h40, 1, 32'h9000, 1); step(32'h40, 0, 0, "nopush.br_wins");
    drv(0, 0, 0, 1, 1, 32'h80, 0, 32'h0, 0);   step(32'h80, 0, 1, "uf.br");
    drv(0, 0, 0, 0, 0, 32'h0, 1, 32'h600, 0);  step(32'h600, 0, 0, "jmp.plain");

    // Exception beats everything with a populated stack
    call_to(32'h1000); step(32'h1000, 1, 0, "exc.c1");
    call_to(32'h2000); step(32'h2000, 2, 0, "exc.c2");
    drv(0, 0, 1, 1, 1, 32'h40, 1, 32'h50, 0); step(32'h80000180, 0, 0, "exc.all");
    idle();            step(32'h80000184, 0, 0, "exc.seq");
    ret_only();        step(32'h80000188, 0, 1, "exc.stack_empty");

    // PC wrap and reset mid call sequence
    drv(0, 0, 0, 0, 1, 32'hFFFFFFFC, 0, 32'h0, 0); step(32'hFFFFFFFC, 0, 0, "wrap.br");
    idle();            step(32'h0, 0, 0, "wrap.seq");
    call_to(32'h700);  step(32'h700, 1, 0, "rst.call");
    drv(1, 0, 1, 1, 0, 32'h0, 1, 32'h900, 1); step(32'h0, 0, 0, "rst.mid");
    idle();            step(32'h4, 0, 0, "rst.seq");
    ret_only();        step(32'h8, 0, 1, "rst.stack_empty");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
